// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline control blocks (hazard controller, forwarding unit).
// Holds register-index constants, the controller state type and the stall/flush bundle.
package pipeline_ctrl_pkg;

    localparam int unsigned       REG_W    = 5;
    localparam logic [REG_W-1:0]  REG_ZERO = 5'd0;

    typedef enum logic {
        RUN      = 1'b0,
        MDU_WAIT = 1'b1
    } ctrl_state_t;

    typedef struct packed {
        logic stall_pc;
        logic stall_ifid;
        logic stall_idex;
        logic stall_exmem;
        logic flush_ifid;
        logic flush_idex;
        logic flush_exmem;
        logic flush_memwb;
    } hz_ctl_t;

    localparam hz_ctl_t CTL_NONE = '0;

    localparam hz_ctl_t CTL_RESET = '{
        flush_ifid:  1'b1,
        flush_idex:  1'b1,
        flush_exmem: 1'b1,
        flush_memwb: 1'b1,
        default:     1'b0
    };

    // Freeze IF..EX/MEM and drop whatever would otherwise retire into WB.
    localparam hz_ctl_t CTL_DMEM = '{
        stall_pc:    1'b1,
        stall_ifid:  1'b1,
        stall_idex:  1'b1,
        stall_exmem: 1'b1,
        flush_memwb: 1'b1,
        default:     1'b0
    };

    localparam hz_ctl_t CTL_MDU = '{
        stall_pc:    1'b1,
        stall_ifid:  1'b1,
        stall_idex:  1'b1,
        flush_exmem: 1'b1,
        default:     1'b0
    };

    localparam hz_ctl_t CTL_DRAIN = '{
        flush_exmem: 1'b1,
        default:     1'b0
    };

    localparam hz_ctl_t CTL_BRANCH = '{
        flush_ifid: 1'b1,
        flush_idex: 1'b1,
        default:    1'b0
    };

    localparam hz_ctl_t CTL_LOAD_USE = '{
        stall_pc:   1'b1,
        stall_ifid: 1'b1,
        flush_idex: 1'b1,
        default:    1'b0
    };

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// Pipeline-side hazard inputs and stall/flush/MDU outputs of the hazard controller.
// The controller connects through the slave modport; the pipeline drives the master side.
interface pipeline_hazard_controller_if
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 16
);

    logic              MemRead_EX;
    logic [REG_W-1:0]  rd_EX;
    logic [REG_W-1:0]  rs1_ID;
    logic [REG_W-1:0]  rs2_ID;
    logic              use_rs1_ID;
    logic              use_rs2_ID;
    logic              branch_taken_EX;
    logic              mdu_op_EX;
    logic              mdu_done;
    logic              dmem_req_MEM;
    logic              dmem_ready;

    logic              stall_PC;
    logic              stall_IFID;
    logic              stall_IDEX;
    logic              stall_EXMEM;
    logic              flush_IFID;
    logic              flush_IDEX;
    logic              flush_EXMEM;
    logic              flush_MEMWB;
    logic              mdu_start;
    logic              mdu_error;
    logic [CNT_W-1:0]  stall_cycles;

    modport master (
        output MemRead_EX, rd_EX, rs1_ID, rs2_ID, use_rs1_ID, use_rs2_ID,
               branch_taken_EX, mdu_op_EX, mdu_done, dmem_req_MEM, dmem_ready,
        input  stall_PC, stall_IFID, stall_IDEX, stall_EXMEM,
               flush_IFID, flush_IDEX, flush_EXMEM, flush_MEMWB,
               mdu_start, mdu_error, stall_cycles
    );

    modport slave (
        input  MemRead_EX, rd_EX, rs1_ID, rs2_ID, use_rs1_ID, use_rs2_ID,
               branch_taken_EX, mdu_op_EX, mdu_done, dmem_req_MEM, dmem_ready,
        output stall_PC, stall_IFID, stall_IDEX, stall_EXMEM,
               flush_IFID, flush_IDEX, flush_EXMEM, flush_MEMWB,
               mdu_start, mdu_error, stall_cycles
    );

endinterface

// File: rtl/pipeline_hazard_controller_load_use.sv
// Combinational load-use compare: a load in EX whose destination is read by the ID instruction.
// x0 never creates a dependency since it is hardwired to zero.
module load_use_detector
    import pipeline_ctrl_pkg::*;
(
    input  logic             mem_read_ex_i,
    input  logic [REG_W-1:0] rd_ex_i,
    input  logic [REG_W-1:0] rs1_id_i,
    input  logic [REG_W-1:0] rs2_id_i,
    input  logic             use_rs1_id_i,
    input  logic             use_rs2_id_i,
    output logic             load_use_o
);

    logic rs1_hit;
    logic rs2_hit;
    logic rd_live;

    always_comb begin
        rd_live    = (rd_ex_i != REG_ZERO);
        rs1_hit    = use_rs1_id_i && (rs1_id_i == rd_ex_i);
        rs2_hit    = use_rs2_id_i && (rs2_id_i == rd_ex_i);
        load_use_o = mem_read_ex_i && rd_live && (rs1_hit || rs2_hit);
    end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage core: dmem wait, MDU start/wait handshake,
// branch redirect and load-use bubbles, plus MDU timeout detection and a stall counter.
module pipeline_hazard_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned MDU_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 16
) (
    input  logic clk,
    input  logic reset,
    pipeline_hazard_controller_if.slave bus
);

    localparam int unsigned      TMO_W    = $clog2(MDU_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MDU_TIMEOUT - 1);

    ctrl_state_t       state_q, state_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              err_q, err_d;
    logic              drain_q, drain_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    hz_ctl_t           ctl;
    logic              start;
    logic              load_use;
    logic              dmem_wait;

    load_use_detector u_load_use (
        .mem_read_ex_i (bus.MemRead_EX),
        .rd_ex_i       (bus.rd_EX),
        .rs1_id_i      (bus.rs1_ID),
        .rs2_id_i      (bus.rs2_ID),
        .use_rs1_id_i  (bus.use_rs1_ID),
        .use_rs2_id_i  (bus.use_rs2_ID),
        .load_use_o    (load_use)
    );

    assign dmem_wait = bus.dmem_req_MEM && !bus.dmem_ready;

    // State/timeout bookkeeping is resolved first and is independent of the dmem
    // freeze; the output selection below then applies the fixed priority order.
    always_comb begin
        ctl     = CTL_NONE;
        start   = 1'b0;
        state_d = state_q;
        tmo_d   = '0;
        err_d   = err_q;
        drain_d = drain_q;

        if (state_q == MDU_WAIT) begin
            tmo_d = tmo_q + TMO_W'(1);
            if (bus.mdu_done) begin
                state_d = RUN;
                tmo_d   = '0;
            end else if (tmo_q == TMO_LAST) begin
                state_d = RUN;
                tmo_d   = '0;
                err_d   = 1'b1;
                drain_d = 1'b1;
            end
        end

        if (dmem_wait) begin
            ctl = CTL_DMEM;
        end else if (state_q == MDU_WAIT) begin
            if (!bus.mdu_done) begin
                ctl = CTL_MDU;
            end
        end else if (drain_q) begin
            // The timed-out MDU op is still in EX; bubble it and do not restart it.
            ctl     = CTL_DRAIN;
            drain_d = 1'b0;
        end else if (bus.branch_taken_EX) begin
            ctl = CTL_BRANCH;
        end else if (bus.mdu_op_EX) begin
            ctl     = CTL_MDU;
            start   = 1'b1;
            state_d = MDU_WAIT;
        end else if (load_use) begin
            ctl = CTL_LOAD_USE;
        end

        if (reset) begin
            ctl   = CTL_RESET;
            start = 1'b0;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (ctl.stall_pc && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            tmo_q   <= '0;
            err_q   <= 1'b0;
            drain_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            drain_q <= drain_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.stall_PC     = ctl.stall_pc;
    assign bus.stall_IFID   = ctl.stall_ifid;
    assign bus.stall_IDEX   = ctl.stall_idex;
    assign bus.stall_EXMEM  = ctl.stall_exmem;
    assign bus.flush_IFID   = ctl.flush_ifid;
    assign bus.flush_IDEX   = ctl.flush_idex;
    assign bus.flush_EXMEM  = ctl.flush_exmem;
    assign bus.flush_MEMWB  = ctl.flush_memwb;
    assign bus.mdu_start    = start;
    assign bus.mdu_error    = err_q && !reset;
    assign bus.stall_cycles = reset ? '0 : cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed scenarios for the hazard controller followed by a randomized run checked
// against a cycle-level behavioural model of the stall/flush rules.
module tb_pipeline_hazard_controller;
    import pipeline_ctrl_pkg::*;

    localparam int unsigned TMO = 8;
    localparam int unsigned CW  = 16;

    logic clk = 1'b0;
    logic reset;
    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned exp_cnt = 0;

    pipeline_hazard_controller_if #(.CNT_W(CW)) bus ();

    pipeline_hazard_controller #(.MDU_TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // {stall PC,IFID,IDEX,EXMEM, flush IFID,IDEX,EXMEM,MEMWB, mdu_start, mdu_error}
    logic [9:0] obs;
    assign obs = {bus.stall_PC, bus.stall_IFID, bus.stall_IDEX, bus.stall_EXMEM,
                  bus.flush_IFID, bus.flush_IDEX, bus.flush_EXMEM, bus.flush_MEMWB,
                  bus.mdu_start, bus.mdu_error};

    // model state
    bit m_wait;
    bit m_drain;
    bit m_err;
    int unsigned m_wcnt;
    int unsigned m_stalls;

    task automatic set_in(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic u1, input logic u2,
                          input logic br, input logic mop, input logic done,
                          input logic dreq, input logic drdy);
        bus.MemRead_EX      = mr;
        bus.rd_EX           = rd;
        bus.rs1_ID          = rs1;
        bus.rs2_ID          = rs2;
        bus.use_rs1_ID      = u1;
        bus.use_rs2_ID      = u2;
        bus.branch_taken_EX = br;
        bus.mdu_op_EX       = mop;
        bus.mdu_done        = done;
        bus.dmem_req_MEM    = dreq;
        bus.dmem_ready      = drdy;
    endtask

    task automatic idle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [9:0] predict(input logic rst, input logic mr, input logic [4:0] rd,
                                           input logic [4:0] rs1, input logic [4:0] rs2,
                                           input logic u1, input logic u2, input logic br,
                                           input logic mop, input logic done,
                                           input logic dreq, input logic drdy);
        logic [7:0] c;
        logic st;
        bit hz;
        c  = 8'b0;
        st = 1'b0;
        hz = mr && (rd != 5'd0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
        if (rst)                  c = 8'b0000_1111;
        else if (dreq && !drdy)   c = 8'b1111_0001;
        else if (m_wait)          c = done ? 8'b0000_0000 : 8'b1110_0010;
        else if (m_drain)         c = 8'b0000_0010;
        else if (br)              c = 8'b0000_1100;
        else if (mop) begin       c = 8'b1110_0010; st = 1'b1; end
        else if (hz)              c = 8'b1100_0100;
        return {c, st, m_err && !rst};
    endfunction

    task automatic test_reset();
        logic [9:0] want;
        reset = 1'b1;
        idle();
        tick();
        #2;
        want = 10'b0000_1111_00;
        total++; if (obs !== want) begin bad++; $display("FAIL reset_outputs got=%b want=%b", obs, want); end
        total++; if (bus.stall_cycles !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", bus.stall_cycles); end
        total++; if (dut.state_q !== RUN) begin bad++; $display("FAIL reset_state got=%0d want=RUN", dut.state_q); end
        reset = 1'b0;
        #1;
        want = 10'b0;
        total++; if (obs !== want) begin bad++; $display("FAIL post_reset got=%b want=%b", obs, want); end
        tick();
        exp_cnt = 0;
    endtask

    task automatic test_load_use();
        logic [9:0] want;
        set_in(1, 5'd5, 5'd5, 5'd9, 1, 0, 0, 0, 0, 0, 0);
        #2;
        want = 10'b1100_0100_00;
        total++; if (obs !== want) begin bad++; $display("FAIL lu_rs1 got=%b want=%b", obs, want); end
        total++; if (bus.stall_cycles !== 16'(exp_cnt)) begin bad++; $display("FAIL lu_cnt0 got=%0d want=%0d", bus.stall_cycles, exp_cnt); end
        tick(); exp_cnt++;
        set_in(0, 5'd0, 5'd5, 5'd9, 1, 0, 0, 0, 0, 0, 0);
        #2;
        want = 10'b0;
        total++; if (obs !== want) begin bad++; $display("FAIL lu_release got=%b want=%b", obs, want); end
        total++; if (bus.stall_cycles !== 16'(exp_cnt)) begin bad++; $display("FAIL lu_cnt1 got=%0d want=%0d", bus.stall_cycles, exp_cnt); end
        tick();
        set_in(1, 5'd0, 5'd0, 5'd0, 1, 1, 0, 0, 0, 0, 0);
        #2;
        total++; if (obs !== want) begin bad++; $display("FAIL lu_x0 got=%b want=%b", obs, want); end
        tick();
        set_in(1, 5'd7, 5'd3, 5'd7, 0, 1, 0, 0, 0, 0, 0);
        #2;
        want = 10'b1100_0100_00;
        total++; if (obs !== want) begin bad++; $display("FAIL lu_rs2 got=%b want=%b", obs, want); end
        tick(); exp_cnt++;
        set_in(1, 5'd7, 5'd3, 5'd7, 0, 0, 0, 0, 0, 0, 0);
        #2;
        want = 10'b0;
        total++; if (obs !== want) begin bad++; $display("FAIL lu_unused got=%b want=%b", obs, want); end
        tick();
    endtask

    task automatic test_branch();
        logic [9:0] want;
        set_in(1, 5'd5, 5'd5, 5'd0, 1, 0, 1, 0, 0, 0, 0);
        #2;
        want = 10'b0000_1100_00;
        total++; if (obs !== want) begin bad++; $display("FAIL branch_over_lu got=%b want=%b", obs, want); end
        tick();
        idle();
        #2;
        total++; if (bus.stall_cycles !== 16'(exp_cnt)) begin bad++; $display("FAIL branch_cnt got=%0d want=%0d", bus.stall_cycles, exp_cnt); end
        tick();
    endtask

    task automatic test_mdu_latency();
        logic [9:0] want;
        int unsigned starts;
        starts = 0;
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        #2;
        want = 10'b1110_0010_10;
        starts += 32'(bus.mdu_start);
        total++; if (obs !== want) begin bad++; $display("FAIL mdu_issue got=%b want=%b", obs, want); end
        tick();
        for (int i = 1; i <= 3; i++) begin
            set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
            #2;
            want = 10'b1110_0010_00;
            starts += 32'(bus.mdu_start);
            total++; if (obs !== want) begin bad++; $display("FAIL mdu_wait%0d got=%b want=%b", i, obs, want); end
            tick();
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        #2;
        want = 10'b0;
        starts += 32'(bus.mdu_start);
        total++; if (obs !== want) begin bad++; $display("FAIL mdu_done got=%b want=%b", obs, want); end
        tick();
        exp_cnt += 4;
        idle();
        #2;
        total++; if (starts != 1) begin bad++; $display("FAIL mdu_start_pulses got=%0d want=1", starts); end
        total++; if (bus.stall_cycles !== 16'(exp_cnt)) begin bad++; $display("FAIL mdu_cnt got=%0d want=%0d", bus.stall_cycles, exp_cnt); end
        total++; if (dut.state_q !== RUN) begin bad++; $display("FAIL mdu_back_run got=%0d want=RUN", dut.state_q); end
        tick();
    endtask

    task automatic test_dmem_in_wait();
        logic [9:0] want;
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
            #2;
            want = 10'b1111_0001_00;
            total++; if (obs !== want) begin bad++; $display("FAIL dmem_hold%0d got=%b want=%b", i, obs, want); end
            total++; if (dut.state_q !== MDU_WAIT) begin bad++; $display("FAIL dmem_state%0d got=%0d want=MDU_WAIT", i, dut.state_q); end
            tick();
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1);
        #2;
        want = 10'b0;
        total++; if (obs !== want) begin bad++; $display("FAIL dmem_done got=%b want=%b", obs, want); end
        tick();
        exp_cnt += 5;
        idle();
        #2;
        total++; if (bus.stall_cycles !== 16'(exp_cnt)) begin bad++; $display("FAIL dmem_cnt got=%0d want=%0d", bus.stall_cycles, exp_cnt); end
        tick();
    endtask

    task automatic test_timeout();
        logic [9:0] want;
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        tick();
        for (int i = 1; i <= int'(TMO); i++) begin
            set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
            #2;
            want = 10'b1110_0010_00;
            total++; if (obs !== want) begin bad++; $display("FAIL tmo_wait%0d got=%b want=%b", i, obs, want); end
            tick();
        end
        exp_cnt += TMO + 1;
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        #2;
        want = 10'b0000_0010_01;
        total++; if (obs !== want) begin bad++; $display("FAIL tmo_drain got=%b want=%b", obs, want); end
        total++; if (dut.state_q !== RUN) begin bad++; $display("FAIL tmo_state got=%0d want=RUN", dut.state_q); end
        tick();
        for (int i = 0; i < 3; i++) begin
            idle();
            #2;
            want = 10'b0000_0000_01;
            total++; if (obs !== want) begin bad++; $display("FAIL tmo_sticky%0d got=%b want=%b", i, obs, want); end
            tick();
        end
        total++; if (bus.stall_cycles !== 16'(exp_cnt)) begin bad++; $display("FAIL tmo_cnt got=%0d want=%0d", bus.stall_cycles, exp_cnt); end
    endtask

    task automatic test_reset_mid_wait();
        logic [9:0] want;
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        tick();
        reset = 1'b1;
        #2;
        want = 10'b0000_1111_00;
        total++; if (obs !== want) begin bad++; $display("FAIL rmid_outputs got=%b want=%b", obs, want); end
        tick();
        #2;
        total++; if (obs !== want) begin bad++; $display("FAIL rmid_held got=%b want=%b", obs, want); end
        total++; if (dut.state_q !== RUN) begin bad++; $display("FAIL rmid_state got=%0d want=RUN", dut.state_q); end
        total++; if (dut.tmo_q !== '0) begin bad++; $display("FAIL rmid_tmo got=%0d want=0", dut.tmo_q); end
        total++; if (bus.stall_cycles !== 16'd0) begin bad++; $display("FAIL rmid_cnt got=%0d want=0", bus.stall_cycles); end
        reset = 1'b0;
        idle();
        #1;
        want = 10'b0;
        total++; if (obs !== want) begin bad++; $display("FAIL rmid_release got=%b want=%b", obs, want); end
        tick();
    endtask

    task automatic test_random();
        logic [9:0] want;
        logic rst, mr, u1, u2, br, mop, done, dreq, drdy;
        logic [4:0] rd, rs1, rs2;
        bit dm;
        reset = 1'b1;
        idle();
        tick();
        reset = 1'b0;
        m_wait = 0; m_drain = 0; m_err = 0; m_wcnt = 0; m_stalls = 0;
        for (int i = 0; i < 600; i++) begin
            rst  = ($urandom_range(0, 59) == 0);
            mr   = $urandom_range(0, 1) == 1;
            rd   = 5'($urandom_range(0, 3));
            rs1  = 5'($urandom_range(0, 3));
            rs2  = 5'($urandom_range(0, 3));
            u1   = $urandom_range(0, 1) == 1;
            u2   = $urandom_range(0, 1) == 1;
            br   = ($urandom_range(0, 6) == 0);
            mop  = ($urandom_range(0, 7) == 0) || m_wait;
            done = m_wait && ($urandom_range(0, 4) == 0);
            dreq = ($urandom_range(0, 3) == 0);
            drdy = $urandom_range(0, 1) == 1;
            reset = rst;
            set_in(mr, rd, rs1, rs2, u1, u2, br, mop, done, dreq, drdy);
            #2;
            want = predict(rst, mr, rd, rs1, rs2, u1, u2, br, mop, done, dreq, drdy);
            total++; if (obs !== want) begin bad++; $display("FAIL rnd_ctl cyc=%0d got=%b want=%b", i, obs, want); end
            total++; if (bus.stall_cycles !== (rst ? 16'd0 : 16'(m_stalls))) begin bad++; $display("FAIL rnd_cnt cyc=%0d got=%0d want=%0d", i, bus.stall_cycles, rst ? 0 : m_stalls); end
            total++; if (dut.state_q !== (m_wait ? MDU_WAIT : RUN)) begin bad++; $display("FAIL rnd_state cyc=%0d got=%0d want=%0d", i, dut.state_q, m_wait); end
            tick();
            dm = dreq && !drdy;
            if (rst) begin
                m_wait = 0; m_drain = 0; m_err = 0; m_wcnt = 0; m_stalls = 0;
            end else begin
                if (want[9] && m_stalls < 65535) m_stalls++;
                if (m_wait) begin
                    m_wcnt++;
                    if (done) m_wait = 0;
                    else if (m_wcnt == TMO) begin m_err = 1; m_wait = 0; m_drain = 1; end
                end else if (m_drain) begin
                    if (!dm) m_drain = 0;
                end else if (want[1]) begin
                    m_wait = 1;
                    m_wcnt = 0;
                end
            end
        end
        reset = 1'b0;
        idle();
    endtask

    initial begin
        reset = 1'b1;
        idle();
        test_reset();
        test_load_use();
        test_branch();
        test_mdu_latency();
        test_dmem_in_wait();
        test_timeout();
        test_reset_mid_wait();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
